csa_accum_sequencer: RTL

Sequencer that sums a stream of NUM_OPS unsigned operands using an internal 4-input carry-save adder stage.
- Collects operands four at a time through a valid/ready input port.
- Reduces each group of four in one ADD cycle into a running accumulator.
- Presents the final total on a valid/ready result port.
- Sits between an operand producer (FIFO or bus) and any consumer of the multi-operand sum.

---
 rtl/csa_accum_sequencer_if.sv | 14 +
 rtl/csa_accum_sequencer.sv | 84 ++++++++
 2 files changed

// File: rtl/csa_accum_sequencer_if.sv
// csa_accum_sequencer_if: operand and result valid/ready ports of the CSA accumulating sequencer
interface csa_accum_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int RES_W = 8
);
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] op_data;
  logic             res_valid;
  logic             res_ready;
  logic [RES_W-1:0] res_data;
  modport master (output op_valid, op_data, res_ready, input op_ready, res_valid, res_data);
  modport slave  (input op_valid, op_data, res_ready, output op_ready, res_valid, res_data);
endinterface

// File: rtl/csa_accum_sequencer.sv
// csa_accum_sequencer: sums NUM_OPS operands four per ADD cycle through a 4:2 carry-save stage.
// Define CSA_SEQ_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module csa_accum_sequencer #(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 8,
  parameter int RES_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  csa_accum_sequencer_if.slave bus,
  output logic                busy,
  output logic                ovf
);
  localparam int GW = WIDTH + 2;
  localparam int SW = (RES_W > GW ? RES_W : GW) + 1;
  typedef enum logic [1:0] {IDLE, LOAD, ADD, DONE} state_t;
  state_t           state, state_nxt;
  logic [WIDTH-1:0] lane [4];
  logic [1:0]       lane_idx;
  logic [7:0]       op_cnt;
  logic [RES_W-1:0] acc, acc_nxt;
  logic [GW-1:0]    a, b, c, d, s1, c1, s2, c2, group;
  logic [SW-1:0]    sum;
  logic             over, take, last_op;
  assign take    = bus.op_valid && bus.op_ready;
  assign last_op = op_cnt + 8'd1 == 8'(NUM_OPS);
  assign a = GW'(lane[0]);
  assign b = GW'(lane[1]);
  assign c = GW'(lane[2]);
  assign d = GW'(lane[3]);
  // two 3:2 compressor layers, then one carry-propagate add; WIDTH+2 bits hold 4*(2^WIDTH-1)
  assign s1    = a ^ b ^ c;
  assign c1    = ((a & b) | (a & c) | (b & c)) << 1;
  assign s2    = s1 ^ c1 ^ d;
  assign c2    = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
  assign group = s2 + c2;
  assign sum   = SW'(acc) + SW'(group);
  assign over  = |sum[SW-1:RES_W];
`ifdef CSA_SEQ_SAT_EN
  assign acc_nxt = over ? '1 : sum[RES_W-1:0];
`else
  assign acc_nxt = sum[RES_W-1:0];
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  always_comb begin
    state_nxt = state == IDLE ? (start ? LOAD : IDLE) :
                state == LOAD ? (take && (lane_idx == 2'd3 || last_op) ? ADD : LOAD) :
                state == ADD  ? (op_cnt == 8'(NUM_OPS) ? DONE : LOAD) :
                                (bus.res_ready ? IDLE : DONE);
  end
  always_comb begin
    bus.op_ready  = state == LOAD;
    bus.res_valid = state == DONE;
    busy          = state != IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc          <= '0;
      ovf          <= 1'b0;
      op_cnt       <= '0;
      lane_idx     <= '0;
      lane         <= '{default: '0};
      bus.res_data <= '0;
    end else if (state == IDLE && start) begin
      acc      <= '0;
      ovf      <= 1'b0;
      op_cnt   <= '0;
      lane_idx <= '0;
      lane     <= '{default: '0};
    end else if (take) begin
      lane[lane_idx] <= bus.op_data;
      lane_idx       <= lane_idx + 2'd1;
      op_cnt         <= op_cnt + 8'd1;
    end else if (state == ADD) begin
      acc      <= acc_nxt;
      ovf      <= ovf | over;
      lane     <= '{default: '0};
      lane_idx <= '0;
      if (op_cnt == 8'(NUM_OPS)) bus.res_data <= acc_nxt;
    end
endmodule
